// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg -- shared definitions for the RTC multiplexed-bus logic.
// Holds the bus-cycle state encodings, the default phase length and the
// strobe decode used by rtc_bus_sched. The same encodings are reused by the
// RTC controller, so the values must stay stable.
package rtc_bus_pkg;

   // Bus-cycle states (legacy-compatible 3-bit encoding)
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_A_SETUP = 3'd1;
   localparam logic [2:0] ST_A_STB   = 3'd2;
   localparam logic [2:0] ST_A_HOLD  = 3'd3;
   localparam logic [2:0] ST_D_SETUP = 3'd4;
   localparam logic [2:0] ST_D_STB   = 3'd5;
   localparam logic [2:0] ST_D_HOLD  = 3'd6;
   localparam logic [2:0] ST_DONE    = 3'd7;

   // Default number of clock cycles spent in each bus phase
   localparam int DEF_PHASE_CYC = 4;

   // Active-low strobes plus the AD drive enable, as one bundle
   typedef struct packed {
      logic cs_n;
      logic ad_n;
      logic wr_n;
      logic rd_n;
      logic ad_oe;
   } strobe_t;

   // Strobe levels for a given state; wr_n doubles as the address latch
   // strobe in A_STB, so it pulses there for reads as well as writes.
   function automatic strobe_t strobe_decode(input logic [2:0] st, input logic is_wr);
      strobe_t s;
      s = '{cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};
      case (st)
         ST_A_SETUP, ST_A_HOLD: begin
            s.cs_n  = 1'b0;
            s.ad_n  = 1'b0;
            s.ad_oe = 1'b1;
         end
         ST_A_STB: begin
            s.cs_n  = 1'b0;
            s.ad_n  = 1'b0;
            s.ad_oe = 1'b1;
            s.wr_n  = 1'b0;
         end
         ST_D_SETUP, ST_D_HOLD: begin
            s.cs_n  = 1'b0;
            s.ad_oe = is_wr;
         end
         ST_D_STB: begin
            s.cs_n  = 1'b0;
            s.ad_oe = is_wr;
            s.wr_n  = ~is_wr;
            s.rd_n  = is_wr;
         end
         default: begin
            s = '{cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// rtc_phase_timer -- down-counter that measures one bus phase.
// Ports:
//   clk   in   system clock
//   reset in   asynchronous active-high reset (counter cleared to 0)
//   load  in   reload the counter for a new phase (asserted on state change)
//   len   in   phase length in cycles, 1..15
//   last  out  high during the final cycle of the current phase
module rtc_phase_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] len,
   output logic       last
);

   logic [3:0] cnt_r;

   // Reload to len-1 so the phase spans exactly len cycles; hold at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= 4'd0;
      end else if (load) begin
         cnt_r <= len - 4'd1;
      end else if (cnt_r != 4'd0) begin
         cnt_r <= cnt_r - 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign last = (cnt_r == 4'd0);

endmodule

// File: rtl/rtc_bus_sched.sv
// rtc_bus_sched -- arbitrates write/read requests onto the multiplexed RTC
// AD bus and sequences the address and data phases.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   req_wr, req_rd      level requests; addr / wr_data latched at grant
//   ad_in               value sampled from the AD bus (read data)
//   gnt_wr, gnt_rd      one-cycle grant pulses
//   busy, done          transaction in progress / one-cycle completion pulse
//   rd_data             last captured read value
//   ad_out, ad_oe       AD bus drive value and enable (ad_oe=0 releases bus)
//   cs_n, rd_n, wr_n, ad_n  active-low RTC strobes (ad_n low = address phase)
// A grant cycle (state still IDLE) precedes A_SETUP, so the sequence is
// grant, six phases of PHASE_CYC cycles, then one DONE cycle.
module rtc_bus_sched
   import rtc_bus_pkg::*;
#(
   parameter int PHASE_CYC = DEF_PHASE_CYC,
   parameter bit WR_FIRST  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_wr,
   input  logic       req_rd,
   input  logic [7:0] addr,
   input  logic [7:0] wr_data,
   input  logic [7:0] ad_in,
   output logic       gnt_wr,
   output logic       gnt_rd,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic       ad_n
);

   localparam logic [3:0] PHASE_LEN = 4'(PHASE_CYC);

   logic [2:0] state_r, state_nxt_s;
   logic       last_s, load_s;
   logic       grant_s, grant_wr_s;
   logic       typ_wr_r, rr_wr_next_r;
   logic [7:0] addr_r, wdat_r, rd_data_r, ad_out_r, ad_out_nxt_s;
   logic       gnt_wr_r, gnt_rd_r, busy_r, done_r;
   strobe_t    stb_r, stb_nxt_s;

   rtc_phase_timer u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (load_s),
      .len   (PHASE_LEN),
      .last  (last_s)
   );

   // Next-state and arbitration; a pending grant blocks re-arbitration
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      grant_wr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (gnt_wr_r || gnt_rd_r) begin
               state_nxt_s = ST_A_SETUP;
            end else if (req_wr || req_rd) begin
               grant_s    = 1'b1;
               grant_wr_s = (req_wr && req_rd) ? rr_wr_next_r : req_wr;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_A_SETUP: state_nxt_s = last_s ? ST_A_STB   : ST_A_SETUP;
         ST_A_STB:   state_nxt_s = last_s ? ST_A_HOLD  : ST_A_STB;
         ST_A_HOLD:  state_nxt_s = last_s ? ST_D_SETUP : ST_A_HOLD;
         ST_D_SETUP: state_nxt_s = last_s ? ST_D_STB   : ST_D_SETUP;
         ST_D_STB:   state_nxt_s = last_s ? ST_D_HOLD  : ST_D_STB;
         ST_D_HOLD:  state_nxt_s = last_s ? ST_DONE    : ST_D_HOLD;
         ST_DONE:    state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   assign load_s = (state_nxt_s != state_r);

   // Output decode from the next state so registered outputs track the state
   always_comb begin
      stb_nxt_s = strobe_decode(state_nxt_s, typ_wr_r);
      case (state_nxt_s)
         ST_A_SETUP, ST_A_STB, ST_A_HOLD: ad_out_nxt_s = addr_r;
         ST_D_SETUP, ST_D_STB, ST_D_HOLD: ad_out_nxt_s = typ_wr_r ? wdat_r : 8'h00;
         default:                         ad_out_nxt_s = 8'h00;
      endcase
   end

   // State, request latches, round-robin pointer and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         typ_wr_r     <= 1'b0;
         rr_wr_next_r <= WR_FIRST;
         addr_r       <= 8'h00;
         wdat_r       <= 8'h00;
         gnt_wr_r     <= 1'b0;
         gnt_rd_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         ad_out_r     <= 8'h00;
         stb_r        <= '{cs_n: 1'b1, ad_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};
      end else begin
         state_r  <= state_nxt_s;
         gnt_wr_r <= grant_s & grant_wr_s;
         gnt_rd_r <= grant_s & ~grant_wr_s;
         busy_r   <= (state_nxt_s != ST_IDLE);
         done_r   <= (state_nxt_s == ST_DONE);
         ad_out_r <= ad_out_nxt_s;
         stb_r    <= stb_nxt_s;
         if (grant_s) begin
            typ_wr_r     <= grant_wr_s;
            rr_wr_next_r <= ~grant_wr_s;
            addr_r       <= addr;
            wdat_r       <= wr_data;
         end else begin
            typ_wr_r     <= typ_wr_r;
            rr_wr_next_r <= rr_wr_next_r;
            addr_r       <= addr_r;
            wdat_r       <= wdat_r;
         end
      end
   end

   // Read capture at the closing edge of the final D_STB cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_r <= 8'h00;
      end else if ((state_r == ST_D_STB) && last_s && !typ_wr_r) begin
         rd_data_r <= ad_in;
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign gnt_wr  = gnt_wr_r;
   assign gnt_rd  = gnt_rd_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign rd_data = rd_data_r;
   assign ad_out  = ad_out_r;
   assign ad_oe   = stb_r.ad_oe;
   assign cs_n    = stb_r.cs_n;
   assign rd_n    = stb_r.rd_n;
   assign wr_n    = stb_r.wr_n;
   assign ad_n    = stb_r.ad_n;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// Self-checking bench for rtc_bus_sched: a default instance (PHASE_CYC=4)
// and a PHASE_CYC=1 instance share all inputs; 'sel' picks which one the
// monitor observes. Expected transactions are queued at stimulus time and
// popped when the observed transaction completes.
module tb_rtc_bus_sched;

   localparam int P0 = 4;
   localparam int P1 = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req_wr = 1'b0, req_rd = 1'b0;
   logic [7:0] addr = 8'h00, wr_data = 8'h00, ad_in = 8'hAA;

   logic       gnt_wr_v[2], gnt_rd_v[2], busy_v[2], done_v[2];
   logic       ad_oe_v[2], cs_n_v[2], rd_n_v[2], wr_n_v[2], ad_n_v[2];
   logic [7:0] rd_data_v[2], ad_out_v[2];

   int cyc = 0;
   int sel = 0;
   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      bit         is_wr;
      logic [7:0] rdval;
      int         gnt_cyc;
      int         done_cyc;
   } exp_t;
   exp_t exp_q[$];

   // observation record filled by watch()
   int         o_ngnt, o_ndone, o_adn, o_adn_ok, o_cs, o_d, o_d_oe, o_d_ok, o_gnt_busy;
   int         o_wr_runs, o_wr_min, o_wr_max, o_rd_runs, o_rd_min, o_rd_max;
   int         o_gnt_cyc[4], o_done_cyc[4];
   bit         o_gnt_wr[4];
   logic [7:0] o_rd_at_done[4];

   rtc_bus_sched #(.PHASE_CYC(P0), .WR_FIRST(1'b1)) dut0 (
      .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd), .addr(addr),
      .wr_data(wr_data), .ad_in(ad_in), .gnt_wr(gnt_wr_v[0]), .gnt_rd(gnt_rd_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .rd_data(rd_data_v[0]), .ad_out(ad_out_v[0]),
      .ad_oe(ad_oe_v[0]), .cs_n(cs_n_v[0]), .rd_n(rd_n_v[0]), .wr_n(wr_n_v[0]), .ad_n(ad_n_v[0])
   );

   rtc_bus_sched #(.PHASE_CYC(P1), .WR_FIRST(1'b1)) dut1 (
      .clk(clk), .reset(reset), .req_wr(req_wr), .req_rd(req_rd), .addr(addr),
      .wr_data(wr_data), .ad_in(ad_in), .gnt_wr(gnt_wr_v[1]), .gnt_rd(gnt_rd_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .rd_data(rd_data_v[1]), .ad_out(ad_out_v[1]),
      .ad_oe(ad_oe_v[1]), .cs_n(cs_n_v[1]), .rd_n(rd_n_v[1]), .wr_n(wr_n_v[1]), .ad_n(ad_n_v[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Observe the selected DUT for up to max_cyc cycles or until ndone_tgt
   // completions. Unless hold is set, requests drop and addr/wr_data are
   // scrambled as soon as a grant is seen. ad_in carries rdv while rd_n is low.
   task automatic watch(input int max_cyc, input int ndone_tgt, input bit hold,
                        input logic [7:0] ea, input logic [7:0] ew, input logic [7:0] rdv);
      int wr_run, rd_run;
      o_ngnt = 0; o_ndone = 0; o_adn = 0; o_adn_ok = 0; o_cs = 0; o_d = 0;
      o_d_oe = 0; o_d_ok = 0; o_gnt_busy = 0;
      o_wr_runs = 0; o_wr_min = 99; o_wr_max = 0;
      o_rd_runs = 0; o_rd_min = 99; o_rd_max = 0;
      for (int k = 0; k < 4; k++) begin
         o_gnt_cyc[k] = -1; o_done_cyc[k] = -1; o_gnt_wr[k] = 1'b0; o_rd_at_done[k] = 8'hxx;
      end
      wr_run = 0; rd_run = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (gnt_wr_v[sel] || gnt_rd_v[sel]) begin
            if (o_ngnt < 4) begin
               o_gnt_cyc[o_ngnt] = cyc;
               o_gnt_wr[o_ngnt]  = gnt_wr_v[sel];
            end
            o_ngnt++;
            if (busy_v[sel] || (gnt_wr_v[sel] && gnt_rd_v[sel])) o_gnt_busy++;
            if (!hold) begin
               req_wr = 1'b0; req_rd = 1'b0; addr = 8'hFF; wr_data = 8'h00;
            end
         end
         if (!cs_n_v[sel]) o_cs++;
         if (!ad_n_v[sel]) begin
            o_adn++;
            if (ad_oe_v[sel] && ad_out_v[sel] == ea) o_adn_ok++;
         end
         if (!cs_n_v[sel] && ad_n_v[sel]) begin
            o_d++;
            if (ad_oe_v[sel]) o_d_oe++;
            if (ad_oe_v[sel] && ad_out_v[sel] == ew) o_d_ok++;
         end
         if (!wr_n_v[sel]) wr_run++;
         else if (wr_run > 0) begin
            o_wr_runs++;
            if (wr_run < o_wr_min) o_wr_min = wr_run;
            if (wr_run > o_wr_max) o_wr_max = wr_run;
            wr_run = 0;
         end
         if (!rd_n_v[sel]) rd_run++;
         else if (rd_run > 0) begin
            o_rd_runs++;
            if (rd_run < o_rd_min) o_rd_min = rd_run;
            if (rd_run > o_rd_max) o_rd_max = rd_run;
            rd_run = 0;
         end
         if (done_v[sel]) begin
            if (o_ndone < 4) begin
               o_done_cyc[o_ndone]   = cyc;
               o_rd_at_done[o_ndone] = rd_data_v[sel];
            end
            o_ndone++;
         end
         ad_in = (rd_n_v[sel] == 1'b0) ? rdv : 8'hAA;
         if (o_ndone >= ndone_tgt) break;
      end
      ad_in = 8'hAA;
   endtask

   task automatic test_reset();
      logic [8:0] v;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         v = {busy_v[d], done_v[d], gnt_wr_v[d], gnt_rd_v[d], cs_n_v[d], rd_n_v[d],
              wr_n_v[d], ad_n_v[d], ad_oe_v[d]};
         n_chk++;
         if (v !== 9'b0000_1111_0) begin
            n_fail++; $display("FAIL reset_ctrl dut%0d: got %b want %b", d, v, 9'b0000_1111_0);
         end
         n_chk++;
         if (ad_out_v[d] !== 8'h00) begin
            n_fail++; $display("FAIL reset_ad_out dut%0d: got %h want 00", d, ad_out_v[d]);
         end
         n_chk++;
         if (rd_data_v[d] !== 8'h00) begin
            n_fail++; $display("FAIL reset_rd_data dut%0d: got %h want 00", d, rd_data_v[d]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_write();
      int n;
      exp_t e;
      sel = 0;
      @(negedge clk);
      req_wr = 1'b1; addr = 8'h21; wr_data = 8'h45;
      n = cyc + 1;
      exp_q.push_back('{1'b1, 8'h00, n, n + 1 + 6 * P0});
      watch(60, 1, 1'b0, 8'h21, 8'h45, 8'h59);
      e = exp_q.pop_front();
      n_chk++;
      if (o_gnt_cyc[0] !== e.gnt_cyc || o_gnt_wr[0] !== e.is_wr) begin
         n_fail++; $display("FAIL wr_grant: got cyc %0d wr %0d want cyc %0d wr 1", o_gnt_cyc[0], o_gnt_wr[0], e.gnt_cyc);
      end
      n_chk++;
      if (o_done_cyc[0] !== e.done_cyc) begin
         n_fail++; $display("FAIL wr_done_cyc: got %0d want %0d", o_done_cyc[0], e.done_cyc);
      end
      n_chk++;
      if (o_adn !== 3 * P0 || o_adn_ok !== 3 * P0) begin
         n_fail++; $display("FAIL wr_addr_phase: got %0d/%0d want %0d", o_adn, o_adn_ok, 3 * P0);
      end
      n_chk++;
      if (o_wr_runs !== 2 || o_wr_min !== P0 || o_wr_max !== P0) begin
         n_fail++; $display("FAIL wr_wrn_runs: got %0d runs len %0d..%0d want 2 of %0d", o_wr_runs, o_wr_min, o_wr_max, P0);
      end
      n_chk++;
      if (o_d !== 3 * P0 || o_d_ok !== 3 * P0) begin
         n_fail++; $display("FAIL wr_data_phase: got %0d/%0d want %0d", o_d, o_d_ok, 3 * P0);
      end
      n_chk++;
      if (o_rd_runs !== 0 || o_cs !== 6 * P0) begin
         n_fail++; $display("FAIL wr_rdn_cs: got rd runs %0d cs %0d want 0 %0d", o_rd_runs, o_cs, 6 * P0);
      end
   endtask

   task automatic test_read();
      int n;
      exp_t e;
      sel = 0;
      @(negedge clk);
      req_rd = 1'b1; addr = 8'h23;
      n = cyc + 1;
      exp_q.push_back('{1'b0, 8'h59, n, n + 1 + 6 * P0});
      watch(60, 1, 1'b0, 8'h23, 8'h00, 8'h59);
      e = exp_q.pop_front();
      n_chk++;
      if (o_gnt_cyc[0] !== e.gnt_cyc || o_gnt_wr[0] !== e.is_wr) begin
         n_fail++; $display("FAIL rd_grant: got cyc %0d wr %0d want cyc %0d wr 0", o_gnt_cyc[0], o_gnt_wr[0], e.gnt_cyc);
      end
      n_chk++;
      if (o_done_cyc[0] !== e.done_cyc) begin
         n_fail++; $display("FAIL rd_done_cyc: got %0d want %0d", o_done_cyc[0], e.done_cyc);
      end
      n_chk++;
      if (o_d !== 3 * P0 || o_d_oe !== 0) begin
         n_fail++; $display("FAIL rd_bus_release: got d %0d oe %0d want %0d 0", o_d, o_d_oe, 3 * P0);
      end
      n_chk++;
      if (o_rd_runs !== 1 || o_rd_min !== P0 || o_rd_max !== P0 || o_wr_runs !== 1) begin
         n_fail++; $display("FAIL rd_strobes: got rd %0d len %0d..%0d wr %0d want 1 of %0d, wr 1", o_rd_runs, o_rd_min, o_rd_max, o_wr_runs, P0);
      end
      n_chk++;
      if (o_adn_ok !== 3 * P0) begin
         n_fail++; $display("FAIL rd_addr_phase: got %0d want %0d", o_adn_ok, 3 * P0);
      end
      n_chk++;
      if (o_rd_at_done[0] !== e.rdval) begin
         n_fail++; $display("FAIL rd_data_at_done: got %h want %h", o_rd_at_done[0], e.rdval);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (rd_data_v[0] !== 8'h59) begin
         n_fail++; $display("FAIL rd_data_hold: got %h want 59", rd_data_v[0]);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      exp_t e;
      sel = 0;
      @(negedge clk);
      reset = 1'b1; req_wr = 1'b1; req_rd = 1'b1; addr = 8'h30; wr_data = 8'h31;
      @(negedge clk);
      reset = 1'b0;
      n = cyc + 1;
      for (int k = 0; k < 3; k++)
         exp_q.push_back('{(k % 2 == 0), 8'h00, n + k * (6 * P0 + 3), n + 6 * P0 + 1 + k * (6 * P0 + 3)});
      watch(120, 3, 1'b1, 8'h30, 8'h31, 8'h66);
      req_wr = 1'b0; req_rd = 1'b0;
      for (int k = 0; k < 3; k++) begin
         e = exp_q.pop_front();
         n_chk++;
         if (o_gnt_cyc[k] !== e.gnt_cyc || o_gnt_wr[k] !== e.is_wr) begin
            n_fail++; $display("FAIL b2b_grant%0d: got cyc %0d wr %0d want cyc %0d wr %0d", k, o_gnt_cyc[k], o_gnt_wr[k], e.gnt_cyc, e.is_wr);
         end
         n_chk++;
         if (o_done_cyc[k] !== e.done_cyc) begin
            n_fail++; $display("FAIL b2b_done%0d: got %0d want %0d", k, o_done_cyc[k], e.done_cyc);
         end
         if (k > 0) begin
            n_chk++;
            if (o_gnt_cyc[k] - o_done_cyc[k-1] !== 2) begin
               n_fail++; $display("FAIL b2b_gap%0d: got %0d want 2", k, o_gnt_cyc[k] - o_done_cyc[k-1]);
            end
         end
      end
      n_chk++;
      if (o_gnt_busy !== 0) begin
         n_fail++; $display("FAIL b2b_gnt_busy: got %0d want 0", o_gnt_busy);
      end
   endtask

   task automatic test_reset_mid();
      int n, dcnt;
      exp_t e;
      sel = 0;
      @(negedge clk);
      req_wr = 1'b1; addr = 8'h40; wr_data = 8'h41;
      watch(10, 1, 1'b0, 8'h40, 8'h41, 8'h00);
      #1;
      n_chk++;
      if (cs_n_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
         n_fail++; $display("FAIL mid_pre: got cs_n %b busy %b want 0 1", cs_n_v[0], busy_v[0]);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if ({cs_n_v[0], ad_oe_v[0], busy_v[0], done_v[0], ad_n_v[0], wr_n_v[0]} !== 6'b100011) begin
         n_fail++; $display("FAIL mid_abort: got %b want 100011", {cs_n_v[0], ad_oe_v[0], busy_v[0], done_v[0], ad_n_v[0], wr_n_v[0]});
      end
      n_chk++;
      if (rd_data_v[0] !== 8'h00 || ad_out_v[0] !== 8'h00) begin
         n_fail++; $display("FAIL mid_regs: got rd %h out %h want 00 00", rd_data_v[0], ad_out_v[0]);
      end
      dcnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done_v[0]) dcnt++;
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done_v[0]) dcnt++;
      end
      n_chk++;
      if (dcnt !== 0) begin
         n_fail++; $display("FAIL mid_no_done: got %0d want 0", dcnt);
      end
      req_rd = 1'b1; addr = 8'h07;
      n = cyc + 1;
      exp_q.push_back('{1'b0, 8'h3C, n, n + 1 + 6 * P0});
      watch(60, 1, 1'b0, 8'h07, 8'h00, 8'h3C);
      e = exp_q.pop_front();
      n_chk++;
      if (o_done_cyc[0] !== e.done_cyc || o_rd_at_done[0] !== e.rdval) begin
         n_fail++; $display("FAIL mid_read_after: got cyc %0d data %h want %0d %h", o_done_cyc[0], o_rd_at_done[0], e.done_cyc, e.rdval);
      end
   endtask

   task automatic test_phase1();
      int n;
      exp_t e;
      sel = 1;
      do_reset();
      @(negedge clk);
      req_wr = 1'b1; addr = 8'h5A; wr_data = 8'hC3;
      n = cyc + 1;
      exp_q.push_back('{1'b1, 8'h00, n, n + 7});
      watch(20, 1, 1'b0, 8'h5A, 8'hC3, 8'h00);
      e = exp_q.pop_front();
      n_chk++;
      if (o_gnt_cyc[0] !== e.gnt_cyc || o_done_cyc[0] !== e.done_cyc) begin
         n_fail++; $display("FAIL p1_wr_timing: got gnt %0d done %0d want %0d %0d", o_gnt_cyc[0], o_done_cyc[0], e.gnt_cyc, e.done_cyc);
      end
      n_chk++;
      if (o_wr_runs !== 2 || o_wr_min !== P1 || o_wr_max !== P1 || o_cs !== 6 * P1) begin
         n_fail++; $display("FAIL p1_wr_strobes: got %0d runs len %0d..%0d cs %0d want 2 of 1, cs 6", o_wr_runs, o_wr_min, o_wr_max, o_cs);
      end
      n_chk++;
      if (o_adn_ok !== 3 * P1 || o_d_ok !== 3 * P1) begin
         n_fail++; $display("FAIL p1_wr_bus: got %0d/%0d want 3/3", o_adn_ok, o_d_ok);
      end
      @(negedge clk);
      req_rd = 1'b1; addr = 8'h12;
      n = cyc + 1;
      exp_q.push_back('{1'b0, 8'hA5, n, n + 7});
      watch(20, 1, 1'b0, 8'h12, 8'h00, 8'hA5);
      e = exp_q.pop_front();
      n_chk++;
      if (o_done_cyc[0] !== e.done_cyc || o_rd_at_done[0] !== e.rdval) begin
         n_fail++; $display("FAIL p1_rd: got cyc %0d data %h want %0d %h", o_done_cyc[0], o_rd_at_done[0], e.done_cyc, e.rdval);
      end
      n_chk++;
      if (o_rd_runs !== 1 || o_rd_max !== P1 || o_wr_runs !== 1 || o_wr_max !== P1) begin
         n_fail++; $display("FAIL p1_rd_strobes: got rd %0d/%0d wr %0d/%0d want 1/1 1/1", o_rd_runs, o_rd_max, o_wr_runs, o_wr_max);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_phase1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
